mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 64-bit-block main-memory port between the instruction-cache miss path and the data-cache miss/write-back path.
- Arbitrates between the two requesters, latches the winner's address and write data, and drives the memory for a fixed latency.
- Returns the read block, or a write completion, to the winner with a one-cycle ack.
- Sits between Icache/Dcache and the memory model; the caches see a private, fixed-protocol memory.

Parameters:
- WORD_SIZE, 16, address and word width.
- BLOCK_SIZE, 64, memory block / cache line width.
- MEM_LATENCY, 4, memory access cycles per transaction (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- i_readM  in  1  Icache block-read request; level, held until i_ack.
- i_address  in  WORD_SIZE  Icache block address.
- i_ack  out  1  one-cycle completion pulse to Icache.
- i_data  out  BLOCK_SIZE  read block; valid only while i_ack=1, else 0.
- d_readM  in  1  Dcache block-read request; level, held until d_ack.
- d_writeM  in  1  Dcache block write-back request; level, held until d_ack.
- d_address  in  WORD_SIZE  Dcache block address.
- d_wdata  in  BLOCK_SIZE  Dcache write-back block.
- d_ack  out  1  one-cycle completion pulse to Dcache.
- d_data  out  BLOCK_SIZE  read block; valid only while d_ack=1 on a read, else 0.
- m_read  out  1  memory read strobe.
- m_write  out  1  memory write strobe.
- m_address  out  WORD_SIZE  latched transaction address.
- m_wdata  out  BLOCK_SIZE  latched write data; 0 on reads.
- m_rdata  in  BLOCK_SIZE  memory read data; valid in the last BUSY cycle.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; latency count=0; owner=none; data buffer=0; every output=0.
- States and transitions:
  - IDLE: sample requests.
    - If any request is present, grant one; latch address, op and wdata; go to BUSY with count=MEM_LATENCY-1.
    - With no request, stay in IDLE.
  - BUSY: m_read or m_write=1, with m_address and m_wdata held constant.
    - Decrement count each cycle.
    - In the cycle count==0, capture m_rdata into the buffer (reads only) and go to DONE.
  - DONE: assert the owner's ack for exactly one cycle, with the buffer on its data port for reads; go to IDLE.
- Latency: request seen in IDLE at cycle 0 -> BUSY in cycles 1..MEM_LATENCY -> ack in cycle MEM_LATENCY+1.
- Back-to-back: the minimum spacing between grants is MEM_LATENCY+2 cycles.
- Priority (base build): Dcache strictly over Icache.
- d_readM and d_writeM together: treated as a write; the read is ignored.
- Requests are sampled only in IDLE. Request changes during BUSY/DONE are ignored, and so are changes to the address or wdata.
- A requester deasserts on the edge that ends its ack cycle. A request still high in the next IDLE cycle is treated as a new transaction.
- Reset mid-BUSY: the transaction is abandoned and no ack is produced; m_read/m_write drop immediately (asynchronously).
- The ack and the data port are never asserted to the non-owner.

Optional Feature:
- MEM_ARBITER_ROUND_ROBIN_EN defined:
  - Keep a 1-bit last-grant pointer, reset to Icache.
  - When both requesters are present, grant the one not granted last. A lone requester is always granted.
  - The pointer updates on each grant.
- MEM_ARBITER_ROUND_ROBIN_EN undefined: fixed Dcache priority; no pointer register.

Decomposition:
- Package mem_arb_pkg:
  - WORD_SIZE/BLOCK_SIZE constants.
  - State typedef {IDLE, BUSY, DONE}.
  - Owner typedef {OWN_NONE, OWN_I, OWN_D}.
  - Op typedef {OP_READ, OP_WRITE}.
- Sub-module mem_arb_grant: combinational grant select from requests plus the optional round-robin pointer.
- The FSM, latency counter, latches and output muxing stay in mem_arbiter.

Test Plan:
- Only i_readM=1 with i_address=16'h0040 at cycle 0, MEM_LATENCY=4, m_rdata=64'hAAAA_BBBB_CCCC_DDDD in cycle 4:
  - m_read=1 in cycles 1-4 with m_address=16'h0040.
  - i_ack=1 and i_data=64'hAAAA_BBBB_CCCC_DDDD in cycle 5 only; d_ack stays 0.
- i_readM and d_readM both asserted in cycle 0:
  - Base build: Dcache is acked in cycle 5 and Icache in cycle 11.
  - MEM_ARBITER_ROUND_ROBIN_EN: Dcache first (pointer reset to I), then Icache. A repeat contention afterwards grants Dcache again.
- d_writeM=1 with d_address=16'h0100, d_wdata=64'h1234_5678_9ABC_DEF0:
  - m_write=1 for 4 cycles with the latched values.
  - d_ack in cycle 5 with d_data=0; m_read stays 0.
- d_readM and d_writeM both high: performs a write only; exactly one d_ack.
- d_address changes from 16'h0100 to 16'h0200 during BUSY: m_address stays 16'h0100.
- reset_n low in cycle 2 of a read:
  - All outputs go 0 immediately.
  - After release, no stale ack occurs; a new request completes normally with full latency.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and widths for the memory arbiter slice.
// Contents:
//   WORD_SIZE / BLOCK_SIZE - address/word width and block width
//   state_t  - arbiter FSM states {IDLE, BUSY, DONE}
//   owner_t  - current transaction owner {OWN_NONE, OWN_I, OWN_D}
//   op_t     - latched operation {OP_READ, OP_WRITE}
// Optional build macro used by the slice: MEM_ARBITER_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int BLOCK_SIZE = 64;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  typedef enum logic {OP_READ, OP_WRITE} op_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the Icache, Dcache and memory-side signals.
// Ports carried:
//   Icache : i_readM, i_address (requests) / i_ack, i_data (responses)
//   Dcache : d_readM, d_writeM, d_address, d_wdata (requests) / d_ack, d_data
//   Memory : m_read, m_write, m_address, m_wdata (to memory) / m_rdata (from memory)
//   Status : busy
// Modports:
//   master - the arbiter view (drives acks, read data and the memory strobes)
//   slave  - the environment view (caches and memory model)
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic                  i_readM;
  logic [WORD_SIZE-1:0]  i_address;
  logic                  i_ack;
  logic [BLOCK_SIZE-1:0] i_data;

  logic                  d_readM;
  logic                  d_writeM;
  logic [WORD_SIZE-1:0]  d_address;
  logic [BLOCK_SIZE-1:0] d_wdata;
  logic                  d_ack;
  logic [BLOCK_SIZE-1:0] d_data;

  logic                  m_read;
  logic                  m_write;
  logic [WORD_SIZE-1:0]  m_address;
  logic [BLOCK_SIZE-1:0] m_wdata;
  logic [BLOCK_SIZE-1:0] m_rdata;

  logic                  busy;

  modport master (
    input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
    output i_ack, i_data, d_ack, d_data, m_read, m_write, m_address, m_wdata, busy
  );

  modport slave (
    output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
    input  i_ack, i_data, d_ack, d_data, m_read, m_write, m_address, m_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_grant.sv
// mem_arb_grant: combinational choice of which cache wins the memory port.
// Ports:
//   i_iReq     - Icache has a pending block read
//   i_dReq     - Dcache has a pending block read or write-back
//   i_lastWasD - last grant went to the Dcache (only with MEM_ARBITER_ROUND_ROBIN_EN)
//   o_grant    - OWN_NONE, OWN_I or OWN_D
// Build option MEM_ARBITER_ROUND_ROBIN_EN: alternate on contention instead
// of giving the Dcache fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic   i_iReq,
  input  logic   i_dReq,
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  input  logic   i_lastWasD,
`endif
  output owner_t o_grant
);

  // Winner selection; a lone requester always wins, contention is
  // resolved either by alternation or by Dcache priority.
  always_comb begin
    o_grant = OWN_NONE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    if (i_iReq && i_dReq) begin
      o_grant = i_lastWasD ? OWN_I : OWN_D;
    end else if (i_dReq) begin
      o_grant = OWN_D;
    end else if (i_iReq) begin
      o_grant = OWN_I;
    end
`else
    if (i_dReq) begin
      o_grant = OWN_D;
    end else if (i_iReq) begin
      o_grant = OWN_I;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 64-bit block memory port between the Icache miss
// path and the Dcache miss/write-back path.
// Ports:
//   clk     - clock, all state changes on the rising edge
//   reset_n - asynchronous active-low reset
//   bus     - mem_arbiter_if.master (cache requests/acks and memory strobes)
// Parameter:
//   MEM_LATENCY - memory cycles per transaction (1..15)
// Build option MEM_ARBITER_ROUND_ROBIN_EN: alternate grants on contention
// using a one-bit last-grant pointer (reset to Icache).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input logic           clk,
  input logic           reset_n,
  mem_arbiter_if.master bus
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t                r_state;
  state_t                w_nextState;
  logic [3:0]            r_count;
  owner_t                r_owner;
  op_t                   r_op;
  logic [WORD_SIZE-1:0]  r_address;
  logic [BLOCK_SIZE-1:0] r_wdata;
  logic [BLOCK_SIZE-1:0] r_buffer;
  owner_t                w_grant;
  logic                  w_dReq;
  logic                  w_grantNow;

  // A simultaneous read+write from the Dcache counts as a single request
  // (it becomes a write when latched).
  assign w_dReq     = bus.d_readM | bus.d_writeM;
  assign w_grantNow = (r_state == IDLE) && (w_grant != OWN_NONE);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic r_lastWasD;

  // Last-grant pointer, updated on every grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lastWasD <= 1'b0;
    end else if (w_grantNow) begin
      r_lastWasD <= (w_grant == OWN_D);
    end
  end

  mem_arb_grant u_grant (
    .i_iReq     (bus.i_readM),
    .i_dReq     (w_dReq),
    .i_lastWasD (r_lastWasD),
    .o_grant    (w_grant)
  );
`else
  mem_arb_grant u_grant (
    .i_iReq  (bus.i_readM),
    .i_dReq  (w_dReq),
    .o_grant (w_grant)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: IDLE samples requests, BUSY runs the latency count
  // down to zero, DONE is the single ack cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_grant != OWN_NONE) w_nextState = BUSY;
      BUSY:    if (r_count == 4'd0) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Transaction latches. Everything is captured at the grant and then held,
  // so request/address/data changes during BUSY/DONE have no effect.
  // Read transactions latch zero write data so m_wdata stays 0 on reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= 4'd0;
      r_owner   <= OWN_NONE;
      r_op      <= OP_READ;
      r_address <= '0;
      r_wdata   <= '0;
      r_buffer  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant != OWN_NONE) begin
            r_count <= LAT_M1;
            r_owner <= w_grant;
            if (w_grant == OWN_D) begin
              r_address <= bus.d_address;
              if (bus.d_writeM) begin
                r_op    <= OP_WRITE;
                r_wdata <= bus.d_wdata;
              end else begin
                r_op    <= OP_READ;
                r_wdata <= '0;
              end
            end else begin
              r_address <= bus.i_address;
              r_op      <= OP_READ;
              r_wdata   <= '0;
            end
          end
        end
        BUSY: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else if (r_op == OP_READ) begin
            r_buffer <= bus.m_rdata;
          end
        end
        DONE:    r_owner <= OWN_NONE;
        default: r_owner <= OWN_NONE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so an asynchronous
  // reset clears the strobes and acks at once.
  assign bus.busy      = (r_state != IDLE);
  assign bus.m_read    = (r_state == BUSY) && (r_op == OP_READ);
  assign bus.m_write   = (r_state == BUSY) && (r_op == OP_WRITE);
  assign bus.m_address = r_address;
  assign bus.m_wdata   = r_wdata;
  assign bus.i_ack     = (r_state == DONE) && (r_owner == OWN_I);
  assign bus.d_ack     = (r_state == DONE) && (r_owner == OWN_D);
  assign bus.i_data    = bus.i_ack ? r_buffer : '0;
  assign bus.d_data    = (bus.d_ack && (r_op == OP_READ)) ? r_buffer : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (MEM_LATENCY = 4).
// A transaction-timeline model predicts every cycle's outputs; directed
// sequences add hand-computed expectations, then random cache traffic runs.
// Honours MEM_ARBITER_ROUND_ROBIN_EN for its grant rule.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;

  mem_arbiter_if busIf ();

  mem_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (busIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: at most one transaction in flight, described by its grant
  // cycle; BUSY spans grant+1..grant+LAT and the ack lands at grant+LAT+1.
  bit         txnValid = 0;
  int         gCyc = 0;
  int         mCyc = 0;
  bit         mOwnerD = 0;
  bit         mWrite = 0;
  logic [15:0] mAddr = '0;
  logic [63:0] mWdata = '0;
  logic [63:0] mRdata = '0;
  bit         lastWasD = 0;
  bit         expIAck = 0;
  bit         expDAck = 0;

  // Compare process plus model update, once per cycle mid-cycle.
  always @(negedge clk) begin
    bit inBusy;
    bit inDone;
    bit iReq;
    bit dReq;
    bit pickD;
    mCyc++;
    if (!reset_n) begin
      txnValid = 0;
      lastWasD = 0;
      expIAck  = 0;
      expDAck  = 0;
      checkBit("rst_busy", busIf.busy, 1'b0);
      checkBit("rst_mread", busIf.m_read, 1'b0);
      checkBit("rst_mwrite", busIf.m_write, 1'b0);
      checkBit("rst_iack", busIf.i_ack, 1'b0);
      checkBit("rst_dack", busIf.d_ack, 1'b0);
    end else begin
      if (txnValid && mCyc > gCyc + LAT + 1) txnValid = 0;
      inBusy  = txnValid && (mCyc >= gCyc + 1) && (mCyc <= gCyc + LAT);
      inDone  = txnValid && (mCyc == gCyc + LAT + 1);
      expIAck = inDone && !mOwnerD;
      expDAck = inDone && mOwnerD;
      checkBit("m_busy", busIf.busy, inBusy || inDone);
      checkBit("m_mread", busIf.m_read, inBusy && !mWrite);
      checkBit("m_mwrite", busIf.m_write, inBusy && mWrite);
      if (inBusy) begin
        checkOutput("m_maddr", 64'(busIf.m_address), 64'(mAddr));
        checkOutput("m_mwdata", busIf.m_wdata, mWrite ? mWdata : 64'h0);
      end
      checkBit("m_iack", busIf.i_ack, expIAck);
      checkBit("m_dack", busIf.d_ack, expDAck);
      checkOutput("m_idata", busIf.i_data, expIAck ? mRdata : 64'h0);
      checkOutput("m_ddata", busIf.d_data, (expDAck && !mWrite) ? mRdata : 64'h0);
      if (txnValid && mCyc == gCyc + LAT) mRdata = busIf.m_rdata;
      if (!txnValid) begin
        iReq = busIf.i_readM;
        dReq = busIf.d_readM || busIf.d_writeM;
        if (iReq || dReq) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          pickD = (iReq && dReq) ? !lastWasD : dReq;
`else
          pickD = dReq;
`endif
          lastWasD = pickD;
          txnValid = 1;
          gCyc     = mCyc;
          mOwnerD  = pickD;
          mWrite   = pickD && busIf.d_writeM;
          mAddr    = pickD ? busIf.d_address : busIf.i_address;
          mWdata   = busIf.d_wdata;
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Single Icache read with literal timing: strobe in cycles 1-4, ack in 5.
  task automatic runSingleRead(input logic [15:0] addr, input logic [63:0] data);
    nextCycle();
    busIf.i_readM   = 1'b1;
    busIf.i_address = addr;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkBit("rd_mread", busIf.m_read, (k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) checkOutput("rd_maddr", 64'(busIf.m_address), 64'(addr));
      checkBit("rd_iack", busIf.i_ack, (k == 5));
      checkOutput("rd_idata", busIf.i_data, (k == 5) ? data : 64'h0);
      checkBit("rd_dack", busIf.d_ack, 1'b0);
      nextCycle();
      busIf.m_rdata = (k == 3) ? data : {$urandom, $urandom};
      if (k == 5) busIf.i_readM = 1'b0;
    end
  endtask

  // Both caches read together: Dcache acked in cycle 5, Icache in cycle 11.
  task automatic runContention();
    nextCycle();
    busIf.i_readM   = 1'b1;
    busIf.i_address = 16'h0011;
    busIf.d_readM   = 1'b1;
    busIf.d_address = 16'h0022;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      checkBit("ct_dack", busIf.d_ack, (k == 5));
      checkBit("ct_iack", busIf.i_ack, (k == 11));
      if (k >= 1 && k <= 4) checkOutput("ct_maddr_d", 64'(busIf.m_address), 64'h22);
      if (k >= 7 && k <= 10) checkOutput("ct_maddr_i", 64'(busIf.m_address), 64'h11);
      nextCycle();
      busIf.m_rdata = {$urandom, $urandom};
      if (k == 5) busIf.d_readM = 1'b0;
      if (k == 11) busIf.i_readM = 1'b0;
    end
  endtask

  // Dcache write-back; the address/data change in cycle 2 must be ignored.
  task automatic runWrite(input bit alsoRead);
    int ackCount;
    ackCount = 0;
    nextCycle();
    busIf.d_writeM  = 1'b1;
    busIf.d_readM   = alsoRead;
    busIf.d_address = 16'h0100;
    busIf.d_wdata   = 64'h1234_5678_9ABC_DEF0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkBit("wr_mwrite", busIf.m_write, (k >= 1 && k <= 4));
      checkBit("wr_mread", busIf.m_read, 1'b0);
      if (k >= 1 && k <= 4) begin
        checkOutput("wr_maddr", 64'(busIf.m_address), 64'h0100);
        checkOutput("wr_mwdata", busIf.m_wdata, 64'h1234_5678_9ABC_DEF0);
      end
      checkBit("wr_dack", busIf.d_ack, (k == 5));
      checkOutput("wr_ddata", busIf.d_data, 64'h0);
      checkBit("wr_iack", busIf.i_ack, 1'b0);
      if (busIf.d_ack) ackCount++;
      nextCycle();
      busIf.m_rdata = {$urandom, $urandom};
      if (k == 1) begin
        busIf.d_address = 16'h0200;
        busIf.d_wdata   = 64'hFFFF_0000_FFFF_0000;
      end
      if (k == 5) begin
        busIf.d_writeM = 1'b0;
        busIf.d_readM  = 1'b0;
      end
    end
    checkOutput("wr_ackcount", 64'(ackCount), 64'd1);
  endtask

  // Reset pulled in cycle 2 of a read: outputs clear at once, no stale ack.
  task automatic runResetMidRead();
    nextCycle();
    busIf.i_readM   = 1'b1;
    busIf.i_address = 16'h0080;
    nextCycle();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkBit("rm_mread", busIf.m_read, 1'b0);
    checkBit("rm_busy", busIf.busy, 1'b0);
    checkBit("rm_iack", busIf.i_ack, 1'b0);
    checkOutput("rm_maddr", 64'(busIf.m_address), 64'h0);
    busIf.i_readM = 1'b0;
    nextCycle();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkBit("rm_nostale_i", busIf.i_ack, 1'b0);
      checkBit("rm_nostale_d", busIf.d_ack, 1'b0);
    end
    runSingleRead(16'h0040, 64'hAAAA_BBBB_CCCC_DDDD);
  endtask

  // Random cache behaviour for one cycle. Requests are held until the
  // model's ack, then dropped or occasionally kept as a fresh request.
  task automatic applyStimulus();
    int r;
    busIf.m_rdata = {$urandom, $urandom};
    if (busIf.i_readM) begin
      if (expIAck) begin
        if ($urandom_range(3) == 0) busIf.i_address = 16'($urandom);
        else busIf.i_readM = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        busIf.i_address = 16'($urandom);
      end
    end else if ($urandom_range(2) == 0) begin
      busIf.i_readM   = 1'b1;
      busIf.i_address = 16'($urandom);
    end
    if (busIf.d_readM || busIf.d_writeM) begin
      if (expDAck && $urandom_range(3) != 0) begin
        busIf.d_readM  = 1'b0;
        busIf.d_writeM = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        busIf.d_address = 16'($urandom);
        busIf.d_wdata   = {$urandom, $urandom};
      end
    end else if ($urandom_range(2) == 0) begin
      r = int'($urandom_range(7));
      busIf.d_readM   = (r == 0) || (r >= 4);
      busIf.d_writeM  = (r <= 3);
      busIf.d_address = 16'($urandom);
      busIf.d_wdata   = {$urandom, $urandom};
    end
  endtask

  initial begin
    busIf.i_readM   = 1'b0;
    busIf.i_address = '0;
    busIf.d_readM   = 1'b0;
    busIf.d_writeM  = 1'b0;
    busIf.d_address = '0;
    busIf.d_wdata   = '0;
    busIf.m_rdata   = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkBit("init_busy", busIf.busy, 1'b0);
    checkBit("init_mread", busIf.m_read, 1'b0);
    checkBit("init_mwrite", busIf.m_write, 1'b0);
    checkOutput("init_maddr", 64'(busIf.m_address), 64'h0);
    checkOutput("init_mwdata", busIf.m_wdata, 64'h0);
    checkOutput("init_idata", busIf.i_data, 64'h0);
    checkOutput("init_ddata", busIf.d_data, 64'h0);
    reset_n = 1'b1;

    $display("[TB] directed sequences");
    runSingleRead(16'h0040, 64'hAAAA_BBBB_CCCC_DDDD);
    runContention();
    runContention();
    runWrite(1'b0);
    runWrite(1'b1);
    runResetMidRead();

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      nextCycle();
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
